// File: rtl/train_scheduler_pkg.sv
// Shared types and constants for the training-run scheduler.
// Holds the FSM state encoding, Q8.8 constants and width helper.
package nn_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FP_H,
        FP_O,
        BP_O,
        BP_H,
        NEXT,
        FIN
    } sched_state_t;

    localparam logic [15:0] Q_ONE  = 16'h0100;
    localparam logic [15:0] Q_ZERO = 16'h0000;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/train_scheduler_if.sv
// Control/status bundle between the run controller and its host.
// master drives run requests, slave is the scheduler itself.
interface train_scheduler_if #(
    parameter int BITS = 16,
    parameter int AW   = 3,
    parameter int EW   = 5
);
    logic            start;
    logic            mode;
    logic            abort;
    logic [BITS-1:0] lr_init;
    logic            FPH;
    logic            FPO;
    logic            BPO;
    logic            BPH;
    logic [AW-1:0]   sample_addr;
    logic [EW-1:0]   epoch;
    logic [BITS-1:0] lr_out;
    logic            busy;
    logic            done;

    modport master (
        output start, mode, abort, lr_init,
        input  FPH, FPO, BPO, BPH,
        input  sample_addr, epoch, lr_out,
        input  busy, done
    );

    modport slave (
        input  start, mode, abort, lr_init,
        output FPH, FPO, BPO, BPH,
        output sample_addr, epoch, lr_out,
        output busy, done
    );

endinterface

// File: rtl/train_scheduler_phase_timer.sv
// Loadable down-counter shared by every phase of the scheduler.
// expire is high while the count sits at zero.
module phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);

    logic [W-1:0] cnt;

    // Load on phase entry, otherwise count down and stop at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/train_scheduler.sv
// Run-level controller: steps samples through the four phases,
// counts samples/epochs and supplies a decaying learning rate.
module train_scheduler
    import nn_ctrl_pkg::*;
#(
    parameter int N_SAMPLES = 8,
    parameter int FP_CYC    = 4,
    parameter int BP_CYC    = 4,
    parameter int EPOCHS    = 16,
    parameter int LR_STEP   = 4,
    parameter int BITS      = 16
) (
    input  logic         clk,
    input  logic         rst,
    train_scheduler_if.slave bus
);

    localparam int AW    = cnt_w(N_SAMPLES);
    localparam int EW    = cnt_w(EPOCHS + 1);
    localparam int MAXC  = (FP_CYC > BP_CYC) ? FP_CYC : BP_CYC;
    localparam int TW    = cnt_w(MAXC);
    localparam logic [TW-1:0] FP_LD = TW'(FP_CYC - 1);
    localparam logic [TW-1:0] BP_LD = TW'(BP_CYC - 1);
    localparam logic [AW-1:0] A_LAST = AW'(N_SAMPLES - 1);

    sched_state_t    state, state_n;
    logic [AW-1:0]   addr_q, addr_n;
    logic [EW-1:0]   ep_q, ep_n;
    logic            mode_q, mode_n;
    logic [BITS-1:0] lr_q, lr_n;
    logic [BITS-1:0] lro_q, lro_n;
    logic            fph_q, fpo_q, bpo_q, bph_q;
    logic            busy_q, done_q;
    logic            t_load, t_exp;
    logic [TW-1:0]   t_val;
    logic [EW-1:0]   ep_tgt;
    int unsigned     sh;

    phase_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (t_load),
        .value  (t_val),
        .expire (t_exp)
    );

    // Next-state, counter updates and timer load decode.
    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        ep_n    = ep_q;
        mode_n  = mode_q;
        lr_n    = lr_q;
        ep_tgt  = mode_q ? EW'(1) : EW'(EPOCHS);
        unique case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_n = FP_H;
                    addr_n  = '0;
                    ep_n    = '0;
                    mode_n  = bus.mode;
                    lr_n    = bus.lr_init;
                end
            end
            FP_H: if (t_exp) state_n = FP_O;
            FP_O: if (t_exp) state_n = mode_q ? NEXT : BP_O;
            BP_O: if (t_exp) state_n = BP_H;
            BP_H: if (t_exp) state_n = NEXT;
            NEXT: begin
                if (addr_q < A_LAST) begin
                    addr_n  = addr_q + 1'b1;
                    state_n = FP_H;
                end else begin
                    addr_n  = '0;
                    ep_n    = ep_q + 1'b1;
                    state_n = (ep_n == ep_tgt) ? FIN : FP_H;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (bus.abort && state != IDLE) begin
            state_n = IDLE;
            addr_n  = '0;
            ep_n    = '0;
        end
        t_load = (state_n != state);
        t_val  = (state_n == BP_O || state_n == BP_H) ? BP_LD : FP_LD;
    end

    // Learning rate for the upcoming epoch, zero when validating.
    always_comb begin
        sh = int'(ep_n) / LR_STEP;
        if (sh > BITS - 1) sh = BITS - 1;
        lro_n = BITS'($signed(lr_n) >>> sh);
        if (mode_n) lro_n = Q_ZERO[BITS-1:0];
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            ep_q   <= '0;
            mode_q <= 1'b0;
            lr_q   <= '0;
            lro_q  <= '0;
            fph_q  <= 1'b0;
            fpo_q  <= 1'b0;
            bpo_q  <= 1'b0;
            bph_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            addr_q <= addr_n;
            ep_q   <= ep_n;
            mode_q <= mode_n;
            lr_q   <= lr_n;
            lro_q  <= lro_n;
            fph_q  <= (state_n == FP_H);
            fpo_q  <= (state_n == FP_O);
            bpo_q  <= (state_n == BP_O);
            bph_q  <= (state_n == BP_H);
            busy_q <= (state_n != IDLE);
            done_q <= (state_n == FIN);
        end
    end

    assign bus.FPH         = fph_q;
    assign bus.FPO         = fpo_q;
    assign bus.BPO         = bpo_q;
    assign bus.BPH         = bph_q;
    assign bus.sample_addr = addr_q;
    assign bus.epoch       = ep_q;
    assign bus.lr_out      = lro_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_train_scheduler.sv
// Directed bench for train_scheduler with N=2, FP=2, BP=3,
// EPOCHS=2, LR_STEP=1.
module tb_train_scheduler;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    train_scheduler_if #(.BITS(16), .AW(1), .EW(2)) bus ();

    train_scheduler #(
        .N_SAMPLES (2),
        .FP_CYC    (2),
        .BP_CYC    (3),
        .EPOCHS    (2),
        .LR_STEP   (1),
        .BITS      (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] ctl();
        return {bus.FPH, bus.FPO, bus.BPO, bus.BPH, bus.done, bus.busy};
    endfunction

    task automatic run_check(input bit md, input logic [15:0] lr);
        int per, total, ep, sa, p;
        logic [3:0]  st;
        logic [15:0] lre;
        per   = md ? 5 : 11;
        total = md ? 10 : 44;
        lre   = 16'h0;
        bus.mode    = md;
        bus.lr_init = lr;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
        bus.mode    = ~md;
        bus.lr_init = 16'h1234;
        for (int c = 0; c <= total; c++) begin
            p  = c % per;
            ep = c / (per * 2);
            sa = (c / per) % 2;
            if (c == total)          st = 4'b0000;
            else if (p < 2)          st = 4'b1000;
            else if (p < 4)          st = 4'b0100;
            else if (!md && p < 7)   st = 4'b0010;
            else if (!md && p < 10)  st = 4'b0001;
            else                     st = 4'b0000;
            lre = md ? 16'h0 : 16'($signed(lr) >>> ep);
            check($sformatf("ctl@%0d", c), ctl(),
                  {st, (c == total), 1'b1});
            check($sformatf("addr@%0d", c), bus.sample_addr, sa);
            check($sformatf("epoch@%0d", c), bus.epoch, ep);
            check($sformatf("lr@%0d", c), bus.lr_out, lre);
            step();
        end
        check("end_ctl", ctl(), 6'b0);
        check("end_epoch", bus.epoch, md ? 1 : 2);
        check("end_lr", bus.lr_out, lre);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.mode    = 1'b0;
        bus.abort   = 1'b0;
        bus.lr_init = 16'h0;
        #12;
        check("rst_ctl", ctl(), 6'b0);
        check("rst_addr", bus.sample_addr, 0);
        check("rst_epoch", bus.epoch, 0);
        check("rst_lr", bus.lr_out, 0);
        rst = 1'b0;
        step();
        check("idle_ctl", ctl(), 6'b0);

        run_check(1'b0, 16'h0100);
        check("hold_lr_pos", bus.lr_out, 16'h0040);
        run_check(1'b0, 16'hFF00);
        check("hold_lr_neg", bus.lr_out, 16'hFFC0);
        run_check(1'b1, 16'h0100);

        bus.mode    = 1'b0;
        bus.lr_init = 16'h0100;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 15; c++) step();
        check("pre_abort_ctl", ctl(), 6'b001001);
        check("pre_abort_addr", bus.sample_addr, 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_ctl", ctl(), 6'b0);
        check("abort_addr", bus.sample_addr, 0);
        check("abort_epoch", bus.epoch, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("post_abort%0d", c), ctl(), 6'b0);
        end

        bus.start = 1'b1;
        step();
        for (int c = 0; c < 15; c++) step();
        check("held_ctl", ctl(), 6'b001001);
        check("held_addr", bus.sample_addr, 1);
        bus.abort = 1'b1;
        step();
        check("held_abort", ctl(), 6'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("both_idle%0d", c), ctl(), 6'b0);
            check($sformatf("both_addr%0d", c), bus.sample_addr, 0);
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
        step();
        check("quiet_idle", ctl(), 6'b0);
        run_check(1'b0, 16'h0100);

        bus.mode    = 1'b0;
        bus.lr_init = 16'h0200;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        check("pre_rst_ctl", ctl(), 6'b010001);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ctl", ctl(), 6'b0);
        check("arst_addr", bus.sample_addr, 0);
        check("arst_epoch", bus.epoch, 0);
        check("arst_lr", bus.lr_out, 0);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("post_rst%0d", c), ctl(), 6'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/train_scheduler.md
# train_scheduler

Sequences one neuron layer pair (hidden + output) through training and validation. For each sample in a sample memory it drives the phase strobes in order: forward-hidden, forward-output, backprop-output, backprop-hidden. It counts samples and epochs, and supplies a per-epoch learning rate (Q8.8) that decays by arithmetic right shift. It sits above the Neuron_ReLU / Neuron_Sigmoid instances as the run-level controller, in place of free-running phase generation.

## Interface
- N_SAMPLES, 8, samples per epoch (≥1)
- FP_CYC, 4, cycles each forward phase is held (≥1)
- BP_CYC, 4, cycles each backprop phase is held (≥1)
- EPOCHS, 16, training epochs per run (≥1)
- LR_STEP, 4, epochs per learning-rate halving (≥1)
- BITS, 16, fixed-point word width (Q8.8)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin run; sampled only in IDLE
- mode  in  1  0 = train, 1 = validate; sampled with start
- abort  in  1  stop run, return to IDLE
- lr_init  in  BITS  signed Q8.8 initial learning rate; sampled with start
- FPH, FPO, BPH, BPO  out  1 each  phase strobes, at most one high
- sample_addr  out  $clog2(N_SAMPLES) (min 1)  current sample index
- epoch  out  $clog2(EPOCHS+1)  completed-epoch count of the current run
- lr_out  out  BITS  signed Q8.8 learning rate for BP phases
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at normal run completion

## Operation
- States: IDLE, FP_H, FP_O, BP_O, BP_H, NEXT, FIN.
- Train path: IDLE → FP_H → FP_O → BP_O → BP_H → NEXT. Validate path: IDLE → FP_H → FP_O → NEXT.
- FP_H/FP_O last FP_CYC cycles; BP_O/BP_H last BP_CYC cycles. A phase counter is loaded on entry and counts down.
- Strobe mapping: FPH in FP_H, FPO in FP_O, BPO in BP_O, BPH in BP_H. All strobes are low in IDLE, NEXT and FIN.
- NEXT (1 cycle): if sample_addr < N_SAMPLES-1, increment it and go to FP_H. Otherwise set sample_addr to 0 and increment epoch. Go to FIN if the new epoch equals EPOCHS (train) or 1 (validate); else go to FP_H.
- FIN (1 cycle): done=1, then IDLE. sample_addr, epoch and lr_out hold their final values in IDLE until the next start.
- lr_out = lr_q >>> min(epoch / LR_STEP, BITS-1), where lr_q is the latched lr_init. The shift is sign-preserving, so negative rates stay negative; e.g. FF00 >>> 1 = FF80. In validate mode lr_out = 0.
- start while busy: ignored. mode and lr_init changes while busy: ignored.
- abort: when high in any busy state, the next state is IDLE. All strobes drop on that edge, done does not pulse, and sample_addr and epoch clear to 0.
- abort and start together in IDLE: abort wins and the block stays in IDLE.

## Timing
- Reset values: state IDLE; all strobes 0; sample_addr 0; epoch 0; lr_out 0; busy 0; done 0; lr_q 0.
- Reset asserted mid-run forces the reset values immediately, without waiting for a clock edge.
- start high at edge k: FPH and busy are high from edge k through edge k+FP_CYC.
- Per-sample cycles: train 2·FP_CYC + 2·BP_CYC + 1; validate 2·FP_CYC + 1.
- done pulses N_SAMPLES·EPOCHS·(train per-sample cycles) cycles after the start edge (train). For validate, the delay is N_SAMPLES·(validate per-sample cycles).
- busy falls on the edge after done.
- All outputs are registered. The strobes are decoded from the registered state only, so they are glitch-free.
- lr_out updates on the edge where epoch increments.

## Structure
- Package nn_ctrl_pkg:
  - state enum sched_state_t
  - Q8.8 constants Q_ONE = 16'h0100 and Q_ZERO
  - localparam function for the counter widths
- Sub-module phase_timer: a loadable down-counter with a `load`/`expire` interface, instantiated once and shared by all phases.
- The top level holds the FSM, the sample/epoch counters and the lr shifter.

## Test plan
- N_SAMPLES=2, FP_CYC=2, BP_CYC=3, EPOCHS=2, train, start pulse → strobe sequence FPH×2, FPO×2, BPO×3, BPH×3, gap×1 per sample; done exactly 44 cycles after start; epoch=2 at done.
- Same parameters, mode=1 → only FPH/FPO assert, BPO/BPH never do; done 10 cycles after start; lr_out=0 throughout.
- LR_STEP=1, lr_init=16'h0100 → lr_out 0100 in epoch 0, 0080 in epoch 1. With lr_init=16'hFF00 → FF00, then FF80.
- abort during BP_O of sample 1 → next cycle all strobes 0, busy 0, sample_addr 0, epoch 0, no done pulse.
- start held high during a run, then start and abort together in IDLE → no restart, no state change; a single start afterwards begins a fresh run from sample 0.
- rst asserted between clock edges during FP_O → FPO, busy and the counters are 0 before the next rising edge; after rst is released the block idles until start.
